// File: rtl/mem_arbiter.sv
// Two-requester (CPU / loader) arbiter for a single synchronous memory; three cycles per access.
// Define MEM_ARB_LD_PRIO_EN to give the loader fixed priority on ties instead of round-robin.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_on,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic        ld_ack,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   owner_ld;
    logic   cpu_valid;
    logic   grant;
    logic   grant_ld;

`ifndef MEM_ARB_LD_PRIO_EN
    // Set when the most recent grant went to the loader, so the CPU wins the next tie.
    logic last_ld;
`endif

    always_comb begin
        cpu_valid = cpu_on & cpu_req;
        grant     = (state == IDLE) && (cpu_valid || ld_req);
`ifdef MEM_ARB_LD_PRIO_EN
        grant_ld  = ld_req;
`else
        grant_ld  = ld_req && !(cpu_valid && last_ld);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ACC;
            ACC:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_ld  <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_we    <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner_ld  <= grant_ld;
                mem_addr  <= grant_ld ? ld_addr  : cpu_addr;
                mem_wdata <= grant_ld ? ld_wdata : cpu_wdata;
                mem_we    <= grant_ld ? ld_we    : cpu_we;
            end else begin
                mem_we    <= 1'b0;
            end
        end
    end

`ifndef MEM_ARB_LD_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ld <= 1'b1;
        end else if (grant) begin
            last_ld <= grant_ld;
        end
    end
`endif

    // Read data from the memory lands in DONE, so the ack and rdata line up.
    always_comb begin
        cpu_ack   = (state == DONE) && !owner_ld;
        ld_ack    = (state == DONE) &&  owner_ld;
        cpu_stall = cpu_req & ~cpu_ack;
        rdata     = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a transaction-level reference model and a simple memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, cpu_on, cpu_req, cpu_we, ld_req, ld_we;
    logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_ack, cpu_stall, ld_ack, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    int tests = 0;
    int fails = 0;
    int cack_count = 0;
    int grant_log[$];
    bit log_en = 1'b0;

    mem_arbiter dut (
        .clk(clk), .reset(reset), .cpu_on(cpu_on),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for the address presented appears one edge later.
    logic [15:0] mem [256];
    logic [15:0] model_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 16'h1000 + 16'(i);
            model_mem[i] = 16'h1000 + 16'(i);
        end
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    // Reference model: one access in flight, described by its owner and how many cycles ago it was granted.
    bit          model_valid = 1'b0;
    bit          busy = 1'b0;
    int          age = 0;
    bit          m_owner_ld = 1'b0;
    bit          m_we = 1'b0;
    bit          m_last_ld = 1'b1;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_wdata = 16'h0000;

    always @(posedge clk) begin
        bit cv, pick_ld;
        if (reset) begin
            model_valid = 1'b1;
            busy        = 1'b0;
            age         = 0;
            m_we        = 1'b0;
            m_addr      = 16'h0000;
            m_wdata     = 16'h0000;
            m_last_ld   = 1'b1;
        end else if (busy) begin
            if (age >= 2) busy = 1'b0;
            else age = age + 1;
        end else begin
            cv = cpu_on && cpu_req;
            if (cv || ld_req) begin
                if (cv && ld_req) begin
`ifdef MEM_ARB_LD_PRIO_EN
                    pick_ld = 1'b1;
`else
                    pick_ld = !m_last_ld;
`endif
                end else begin
                    pick_ld = ld_req;
                end
                busy       = 1'b1;
                age        = 1;
                m_owner_ld = pick_ld;
                m_last_ld  = pick_ld;
                m_addr     = pick_ld ? ld_addr  : cpu_addr;
                m_wdata    = pick_ld ? ld_wdata : cpu_wdata;
                m_we       = pick_ld ? ld_we    : cpu_we;
                if (m_we) model_mem[m_addr[7:0]] = m_wdata;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%04h, expected 0x%04h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        bit exp_we, exp_cack, exp_lack;
        if (model_valid) begin
            exp_we   = busy && (age == 1) && m_we;
            exp_cack = busy && (age == 2) && !m_owner_ld;
            exp_lack = busy && (age == 2) &&  m_owner_ld;
            checkOutput("mem_we",    {15'b0, mem_we},    {15'b0, exp_we});
            checkOutput("mem_addr",  mem_addr,           m_addr);
            checkOutput("mem_wdata", mem_wdata,          m_wdata);
            checkOutput("cpu_ack",   {15'b0, cpu_ack},   {15'b0, exp_cack});
            checkOutput("ld_ack",    {15'b0, ld_ack},    {15'b0, exp_lack});
            checkOutput("cpu_stall", {15'b0, cpu_stall}, {15'b0, cpu_req && !exp_cack});
            if ((exp_cack || exp_lack) && !m_we)
                checkOutput("rdata", rdata, model_mem[m_addr[7:0]]);
        end
        if (cpu_ack) cack_count++;
        if (log_en && cpu_ack) grant_log.push_back(0);
        if (log_en && ld_ack)  grant_log.push_back(1);
    end

    task automatic applyStimulus(input logic r, input logic on, input logic cr, input logic cw,
                                 input logic [15:0] ca, input logic [15:0] cd,
                                 input logic lr, input logic lw,
                                 input logic [15:0] la, input logic [15:0] ldat, input int cycles);
        reset = r;  cpu_on = on;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ld_req = lr;  ld_we = lw;  ld_addr = la;  ld_wdata = ldat;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, n);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 2);
        checkOutput("reset_mem_we",   {15'b0, mem_we},  16'h0);
        checkOutput("reset_mem_addr", mem_addr,         16'h0);
        checkOutput("reset_mem_wdata", mem_wdata,       16'h0);
        checkOutput("reset_cpu_ack",  {15'b0, cpu_ack}, 16'h0);
        checkOutput("reset_ld_ack",   {15'b0, ld_ack},  16'h0);

        // Loader write with CPU disabled.
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hA5A5, 1);
        checkOutput("ld_wr_mem_we",    {15'b0, mem_we}, 16'h1);
        checkOutput("ld_wr_mem_addr",  mem_addr,        16'h0010);
        checkOutput("ld_wr_mem_wdata", mem_wdata,       16'hA5A5);
        checkOutput("ld_wr_ack_early", {15'b0, ld_ack}, 16'h0);
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("ld_wr_ack",       {15'b0, ld_ack}, 16'h1);
        checkOutput("ld_wr_we_clear",  {15'b0, mem_we}, 16'h0);
        idleCycles(1);

        // CPU reads back the loader's data.
        applyStimulus(0, 1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("cpu_rd_stall", {15'b0, cpu_stall}, 16'h1);
        applyStimulus(0, 1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("cpu_rd_ack",     {15'b0, cpu_ack},   16'h1);
        checkOutput("cpu_rd_rdata",   rdata,              16'hA5A5);
        checkOutput("cpu_rd_nostall", {15'b0, cpu_stall}, 16'h0);
        idleCycles(1);

        // Both requesters continuously from a fresh reset.
        applyStimulus(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        grant_log.delete();
        log_en = 1'b1;
        applyStimulus(0, 1, 1, 1, 16'h0020, 16'h1111, 1, 1, 16'h0030, 16'h2222, 12);
        idleCycles(2);
        log_en = 1'b0;
        checkOutput("grant_count", 16'(grant_log.size()), 16'd4);
        for (int i = 0; i < grant_log.size(); i++) begin
`ifdef MEM_ARB_LD_PRIO_EN
            checkOutput("grant_order", 16'(grant_log[i]), 16'd1);
`else
            checkOutput("grant_order", 16'(grant_log[i]), 16'(i % 2));
`endif
        end

        // CPU request ignored while cpu_on is low.
        cack_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0, 1);
            checkOutput("cpu_off_stall", {15'b0, cpu_stall}, 16'h1);
        end
        checkOutput("cpu_off_no_ack", 16'(cack_count), 16'd0);
        idleCycles(1);

        // Reset during the ACC cycle of a CPU write aborts it.
        cack_count = 0;
        applyStimulus(0, 1, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("abort_mem_we",   {15'b0, mem_we}, 16'h1);
        checkOutput("abort_mem_addr", mem_addr,        16'h0040);
        applyStimulus(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("abort_we_clear", {15'b0, mem_we}, 16'h0);
        idleCycles(3);
        checkOutput("abort_no_ack", 16'(cack_count), 16'd0);

        // Loader reads the location written during the contention run.
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0, 1);
        idleCycles(1);
        checkOutput("ld_rd_ack", {15'b0, ld_ack}, 16'h1);
`ifdef MEM_ARB_LD_PRIO_EN
        checkOutput("ld_rd_rdata", rdata, 16'h1020);
`else
        checkOutput("ld_rd_rdata", rdata, 16'h1111);
`endif
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
